// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes over a 128-bit block with a ready/valid handshake.
// Define INV_SUB_BYTES_FOUR_LANE_EN for four S-box lanes (4-cycle latency); default is one lane (16 cycles).

module invSBox (
    input  logic [7:0] data,
    output logic [7:0] result
);
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign result = INV_SBOX[data];
endmodule

module inv_sub_bytes_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
`ifdef INV_SUB_BYTES_FOUR_LANE_EN
    localparam int unsigned LANES = 4;
`else
    localparam int unsigned LANES = 1;
`endif
    localparam int unsigned STEPS = 16 / LANES;
    localparam int unsigned CNT_W = $clog2(STEPS);
    localparam int unsigned LW    = 8 * LANES;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    // Segment 0 sits in the MSBs, so the counter walks byte/column 0 first.
    logic [0:STEPS-1][LW-1:0] work, work_next;
    logic [127:0] out_data_next;
    logic [0:LANES-1][7:0] seg_in, seg_out;

    assign seg_in = work[cnt];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        invSBox u_sbox (
            .data   (seg_in[j]),
            .result (seg_out[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            work     <= '0;
            out_data <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            work     <= work_next;
            out_data <= out_data_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        work_next     = work;
        out_data_next = out_data;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    work_next  = in_data;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                work_next[cnt] = seg_out;
                cnt_next       = cnt + 1'b1;
                // Publish only the finished block; out_data then holds it until the next completion.
                if (cnt == LAST) begin
                    out_data_next = work_next;
                    state_next    = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed and randomised checks for inv_sub_bytes_seq against a GF(2^8)-derived S-box model.

module tb_inv_sub_bytes_seq;
`ifdef INV_SUB_BYTES_FOUR_LANE_EN
    localparam int LAT = 4;
    localparam int MID = 2;
`else
    localparam int LAT = 16;
    localparam int MID = 7;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    inv_sub_bytes_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [127:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic release_blk();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [127:0] d, exp_v, back;
        logic [7:0] b, s;

        // Forward S-box from multiplicative inverse + affine map; inverse table by inversion.
        for (int x = 0; x < 256; x++) begin
            b = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        chk("rst_async_in_ready", 128'(in_ready), 128'(1));
        chk("rst_async_out_valid", 128'(out_valid), 128'(0));
        chk("rst_async_busy", 128'(busy), 128'(0));
        chk("rst_async_out_data", out_data, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // First accept on the first edge after reset release.
        rst_n = 1'b1;
        send({16{8'h63}});
        chk("run_busy", 128'(busy), 128'(1));
        chk("run_in_ready", 128'(in_ready), 128'(0));
        chk("run_out_valid", 128'(out_valid), 128'(0));
        wait_done(cyc);
        chk("lat_63", 128'(cyc), 128'(LAT));
        chk("data_63", out_data, '0);
        release_blk();
        chk("rel_out_valid", 128'(out_valid), 128'(0));
        chk("rel_in_ready", 128'(in_ready), 128'(1));
        chk("rel_busy", 128'(busy), 128'(0));
        chk("rel_hold", out_data, '0);

        send(128'hd42711aee0bf98f1b8b45de51e415230);
        wait_done(cyc);
        chk("lat_fips", 128'(cyc), 128'(LAT));
        chk("data_fips", out_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        release_blk();

        send('0);
        wait_done(cyc);
        chk("lat_stall", 128'(cyc), 128'(LAT));
        for (int i = 0; i < 20; i++) begin
            chk("stall_data", out_data, {16{8'h52}});
            chk("stall_valid", 128'(out_valid), 128'(1));
            @(posedge clk); #1;
        end
        release_blk();
        chk("stall_in_ready", 128'(in_ready), 128'(1));
        chk("stall_hold", out_data, {16{8'h52}});

        // Late in_valid and stray out_ready during RUN must be ignored.
        send(128'hd42711aee0bf98f1b8b45de51e415230);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = '1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("ignore_busy", 128'(busy), 128'(1));
        wait_done(cyc);
        chk("lat_ignore", 128'(cyc + 2), 128'(LAT));
        chk("data_ignore", out_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        release_blk();

        // Abort mid-RUN.
        send({16{8'h11}});
        for (int i = 0; i < MID; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_out_data", out_data, 128'h0);
        @(posedge clk); #1;
        chk("abort_hold_valid", 128'(out_valid), 128'(0));
        rst_n = 1'b1;
        send({16{8'h7c}});
        wait_done(cyc);
        chk("lat_7c", 128'(cyc), 128'(LAT));
        chk("data_7c", out_data, {16{8'h01}});
        release_blk();

        for (int n = 0; n < 1000; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 16; i++) exp_v[8*(15-i) +: 8] = inv_tab[d[8*(15-i) +: 8]];
            send(d);
            wait_done(cyc);
            chk("rnd_lat", 128'(cyc), 128'(LAT));
            chk("rnd_data", out_data, exp_v);
            for (int i = 0; i < 16; i++) back[8*(15-i) +: 8] = fwd_tab[out_data[8*(15-i) +: 8]];
            chk("rnd_roundtrip", back, d);
            release_blk();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
